pfpu_f2i_pipe: RTL and testbench
================================

# pfpu_f2i_pipe

Parametrised, fully pipelined float-to-integer converter for the FPU datapath: the successor to the 32-bit f2i pre-stage. It takes a raw IEEE-754 operand of configurable exponent and fraction width and completes the conversion in three advancing stages: classify, align and round/saturate. It produces a final INT_W-bit signed or unsigned integer with IEEE invalid and inexact flags, so no external shifter or rounding stage is needed. It sits beside the other FPU units and obeys the common adv/flush pipe control.

## Interface
Parameters:
- EXP_W, 8, exponent field width (5..11)
- FRAC_W, 23, fraction field width (4..52)
- INT_W, 32, integer result width (8..64)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush_i  in  1  flush pipe, clears all valid bits
- adv_i  in  1  advance pipe; no register changes when low
- start_i  in  1  operand valid in stage-1 input
- opa_i  in  EXP_W+FRAC_W+1  raw float {sign, exp, frac}
- unsigned_i  in  1  1 = unsigned result, 0 = two's-complement signed
- rmode_i  in  2  00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
- f2i_rdy_o  out  1  result valid
- f2i_int_o  out  INT_W  integer result
- f2i_inv_o  out  1  invalid flag (NaN, Inf, out of range)
- f2i_inx_o  out  1  inexact flag

## Operation
Constants: BIAS = 2^(EXP_W-1)-1, and E = exp - BIAS. A denormal input uses hidden bit 0 and E = 1-BIAS. The significand is M = {hidden, frac}.

- Stage 1 (classify):
  - NaN: exp all-ones, frac ≠ 0.
  - Inf: exp all-ones, frac = 0.
  - Zero: exp = 0, frac = 0.
  - huge: E ≥ INT_W+1.
  - Compute the left/right shift amount that places the binary point below bit 0 of an INT_W+1-bit magnitude.
  - Register sign, mode, class and shift with M.
- Stage 2 (align):
  - Shift M into an INT_W+1-bit magnitude plus a guard bit.
  - Right shift is saturated so every lost bit ORs into sticky.
  - A shift larger than FRAC_W+2 yields magnitude 0, guard 0 and sticky = (M≠0).
- Stage 3 (round/saturate):
  - Increment condition by mode:
    - RNE: guard & (sticky | lsb).
    - RTZ: never.
    - +inf: ~sign & (guard|sticky).
    - -inf: sign & (guard|sticky).
  - The rounded magnitude is INT_W+1 bits plus carry.
  - Range check after rounding:
    - Signed positive: ≤ 2^(INT_W-1)-1.
    - Signed negative: ≤ 2^(INT_W-1).
    - Unsigned positive: ≤ 2^INT_W-1.
    - Unsigned negative: rounded magnitude must be 0.
  - Results:
    - In range: value, negated if sign.
    - NaN: max positive.
    - +Inf or positive out of range: max positive.
    - -Inf or negative out of range: min.
    - Max positive is 2^(INT_W-1)-1 signed, 2^INT_W-1 unsigned.
    - Min is -2^(INT_W-1) signed, 0 unsigned.
  - f2i_inv_o = NaN | Inf | huge | out of range.
  - f2i_inx_o = (guard|sticky) & ~f2i_inv_o.
  - -0.0 gives 0 with no flags.

## Timing
- Latency: exactly 3 cycles with adv_i high. An operand accepted at edge N (start_i & adv_i) gives f2i_rdy_o = 1 after edge N+2 with adv_i continuously high.
- Throughput: one result per advancing cycle.
- Valid bits v1, v2, rdy:
  - On adv_i: v1 ← start_i, v2 ← v1, rdy ← v2.
  - When adv_i is low, all data and valid registers hold.
- Flush: flush_i clears v1, v2 and rdy at the next edge regardless of adv_i. Flush takes priority over an accompanying start_i & adv_i.
- Data registers update on adv_i independent of valid. Their contents are don't-care while the matching valid bit is 0.
- Reset (rst = 0): asynchronous.
  - f2i_rdy_o = 0, f2i_int_o = 0, f2i_inv_o = 0, f2i_inx_o = 0.
  - All internal valid and data registers are 0.
  - Reset mid-operation discards in-flight operands; the first result after release needs a new start.
- Outputs are driven directly from stage-3 registers, with no combinational path from inputs.

## Test plan
Defaults EXP_W=8, FRAC_W=23, INT_W=32.
- Rounding, signed:
  - 0x3FC00000 (1.5), RNE → 2, inx=1.
  - 0x3FC00000 (1.5), RTZ → 1, inx=1.
  - 0xC0200000 (-2.5), RNE → 0xFFFFFFFE.
  - 0xC0200000 (-2.5), -inf → 0xFFFFFFFD.
  - 0xC0200000 (-2.5), +inf → 0xFFFFFFFE.
- Range edges:
  - 0x4F000000 signed → 0x7FFFFFFF, inv=1.
  - 0xCF000000 signed → 0x80000000, inv=0, inx=0.
  - 0x4F000000 unsigned → 0x80000000.
  - 0x4F7FFFFF unsigned → 0xFFFFFF00.
  - 0x4F800000 unsigned → 0xFFFFFFFF, inv=1.
- Specials:
  - 0x7FC00000 → 0x7FFFFFFF, inv.
  - 0xFF800000 → 0x80000000, inv.
  - 0x00000001 +inf → 1, inx.
  - 0x80000000 → 0, no flags.
- Unsigned negatives:
  - 0xBF800000 → 0, inv=1.
  - 0xBE800000 RTZ → 0, inv=0, inx=1.
  - 0xBF000000 -inf → 0, inv=1.
- Pipeline control:
  - 5 back-to-back starts with adv_i low on cycle 3: results appear in order and stall exactly one cycle.
  - flush_i together with start_i & adv_i: no rdy for the flushed operands.
  - rst asserted with 2 operands in flight: all outputs 0 immediately, no stale rdy after release.
- Parameter sweep: EXP_W=11, FRAC_W=52, INT_W=64. 0x43E0000000000000 signed → 0x7FFFFFFFFFFFFFFF, inv; 0x4330000000000001 → 0x0010000000000001.

Source files
------------

// File: rtl/pfpu_f2i_pipe.sv
// Three-stage float-to-integer converter: classify, align, round/saturate.
// Produces a signed or unsigned INT_W-bit result with invalid/inexact flags.
module pfpu_f2i_pipe #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int INT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    adv_i,
   input  logic                    start_i,
   input  logic [EXP_W+FRAC_W:0]   opa_i,
   input  logic                    unsigned_i,
   input  logic [1:0]              rmode_i,
   output logic                    f2i_rdy_o,
   output logic [INT_W-1:0]        f2i_int_o,
   output logic                    f2i_inv_o,
   output logic                    f2i_inx_o
);

   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int MW   = FRAC_W + 1;          // significand with hidden bit
   localparam int MAGW = INT_W + 1;           // aligned magnitude width
   localparam int LW   = MAGW + MW;           // left-shift scratch width
   localparam int RW   = MW + FRAC_W + 2;     // right-shift scratch: M plus room for every lost bit
   localparam int SHW  = 16;                  // signed shift amount width
   localparam int RNDW = INT_W + 2;           // rounded magnitude plus carry

   localparam logic [RNDW-1:0]  ONE_R  = RNDW'(1);
   localparam logic [RNDW-1:0]  LIM_SP = (ONE_R << (INT_W - 1)) - ONE_R;
   localparam logic [RNDW-1:0]  LIM_SN = ONE_R << (INT_W - 1);
   localparam logic [RNDW-1:0]  LIM_UP = (ONE_R << INT_W) - ONE_R;
   localparam logic [INT_W-1:0] MAX_S  = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0] MIN_S  = {1'b1, {(INT_W-1){1'b0}}};

   logic v1_q, v2_q, rdy_q;

   // stage 1 registers
   logic             s1_sign_d, s1_sign_q, s1_uns_q;
   logic [1:0]       s1_rmode_q;
   logic             s1_nan_d, s1_nan_q, s1_inf_d, s1_inf_q, s1_huge_d, s1_huge_q;
   logic [SHW-1:0]   s1_sh_d, s1_sh_q;
   logic [MW-1:0]    s1_m_d, s1_m_q;

   // stage 2 registers
   logic             s2_sign_q, s2_uns_q, s2_nan_q, s2_inf_q, s2_huge_q;
   logic [1:0]       s2_rmode_q;
   logic [MAGW-1:0]  s2_mag_d, s2_mag_q;
   logic             s2_g_d, s2_g_q, s2_s_d, s2_s_q;

   // stage 3 registers
   logic [INT_W-1:0] int_d, int_q;
   logic             inv_d, inv_q, inx_d, inx_q;

   logic [EXP_W-1:0]  exp_f;
   logic [FRAC_W-1:0] frac_f;
   int                e_unb;
   logic [LW-1:0]     lwide;
   logic [RW-1:0]     rwide;
   logic [SHW-1:0]    rsh;
   logic              inc, gs, in_range;
   logic [RNDW-1:0]   rnd;
   logic [INT_W-1:0]  rnd_lo, max_pos, min_neg;

   // Stage 1: split fields, classify and compute the signed alignment shift.
   always_comb begin
      s1_sign_d = opa_i[EXP_W+FRAC_W];
      exp_f     = opa_i[FRAC_W +: EXP_W];
      frac_f    = opa_i[FRAC_W-1:0];
      s1_nan_d  = (&exp_f) & (|frac_f);
      s1_inf_d  = (&exp_f) & ~(|frac_f);
      s1_m_d    = {|exp_f, frac_f};
      e_unb     = (exp_f == '0) ? (1 - BIAS) : (int'(exp_f) - BIAS);
      s1_huge_d = (e_unb >= INT_W + 1);
      // positive = left shift, negative = right shift of M
      s1_sh_d   = SHW'(e_unb - FRAC_W);
   end

   // Stage 2: align M to the integer binary point, collecting guard and sticky.
   always_comb begin
      s2_mag_d = '0;
      s2_g_d   = 1'b0;
      s2_s_d   = 1'b0;
      lwide    = '0;
      rwide    = '0;
      rsh      = '0;
      if (!s1_sh_q[SHW-1]) begin
         lwide    = LW'(s1_m_q) << s1_sh_q;
         s2_mag_d = MAGW'(lwide);
      end else begin
         rsh = -s1_sh_q;
         if (rsh > SHW'(FRAC_W + 2)) begin
            s2_s_d = |s1_m_q;
         end else begin
            rwide    = {s1_m_q, {(FRAC_W+2){1'b0}}} >> rsh;
            s2_mag_d = MAGW'(rwide[RW-1 -: MW]);
            s2_g_d   = rwide[FRAC_W+1];
            s2_s_d   = |rwide[FRAC_W:0];
         end
      end
   end

   // Stage 3: round by mode, range-check the rounded magnitude, saturate.
   always_comb begin
      gs = s2_g_q | s2_s_q;
      case (s2_rmode_q)
         2'b00:   inc = s2_g_q & (s2_s_q | s2_mag_q[0]);
         2'b01:   inc = 1'b0;
         2'b10:   inc = ~s2_sign_q & gs;
         default: inc = s2_sign_q & gs;
      endcase
      rnd    = RNDW'(s2_mag_q) + RNDW'(inc);
      rnd_lo = rnd[INT_W-1:0];
      if (s2_uns_q) in_range = s2_sign_q ? (rnd == '0) : (rnd <= LIM_UP);
      else          in_range = s2_sign_q ? (rnd <= LIM_SN) : (rnd <= LIM_SP);
      max_pos = s2_uns_q ? '1 : MAX_S;
      min_neg = s2_uns_q ? '0 : MIN_S;
      int_d   = s2_sign_q ? -rnd_lo : rnd_lo;
      inv_d   = 1'b0;
      if (s2_nan_q) begin
         int_d = max_pos;
         inv_d = 1'b1;
      end else if (s2_inf_q | s2_huge_q | ~in_range) begin
         int_d = s2_sign_q ? min_neg : max_pos;
         inv_d = 1'b1;
      end
      inx_d = gs & ~inv_d;
   end

   // Valid chain: flush wins over advance; holds when adv_i is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         rdy_q <= 1'b0;
      end else if (flush_i) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         rdy_q <= 1'b0;
      end else if (adv_i) begin
         v1_q  <= start_i;
         v2_q  <= v1_q;
         rdy_q <= v2_q;
      end
   end

   // Data registers advance with adv_i regardless of valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_sign_q  <= 1'b0;
         s1_uns_q   <= 1'b0;
         s1_rmode_q <= '0;
         s1_nan_q   <= 1'b0;
         s1_inf_q   <= 1'b0;
         s1_huge_q  <= 1'b0;
         s1_sh_q    <= '0;
         s1_m_q     <= '0;
         s2_sign_q  <= 1'b0;
         s2_uns_q   <= 1'b0;
         s2_rmode_q <= '0;
         s2_nan_q   <= 1'b0;
         s2_inf_q   <= 1'b0;
         s2_huge_q  <= 1'b0;
         s2_mag_q   <= '0;
         s2_g_q     <= 1'b0;
         s2_s_q     <= 1'b0;
         int_q      <= '0;
         inv_q      <= 1'b0;
         inx_q      <= 1'b0;
      end else if (adv_i) begin
         s1_sign_q  <= s1_sign_d;
         s1_uns_q   <= unsigned_i;
         s1_rmode_q <= rmode_i;
         s1_nan_q   <= s1_nan_d;
         s1_inf_q   <= s1_inf_d;
         s1_huge_q  <= s1_huge_d;
         s1_sh_q    <= s1_sh_d;
         s1_m_q     <= s1_m_d;
         s2_sign_q  <= s1_sign_q;
         s2_uns_q   <= s1_uns_q;
         s2_rmode_q <= s1_rmode_q;
         s2_nan_q   <= s1_nan_q;
         s2_inf_q   <= s1_inf_q;
         s2_huge_q  <= s1_huge_q;
         s2_mag_q   <= s2_mag_d;
         s2_g_q     <= s2_g_d;
         s2_s_q     <= s2_s_d;
         int_q      <= int_d;
         inv_q      <= inv_d;
         inx_q      <= inx_d;
      end
   end

   assign f2i_rdy_o = rdy_q;
   assign f2i_int_o = int_q;
   assign f2i_inv_o = inv_q;
   assign f2i_inx_o = inx_q;

endmodule

// File: tb/tb_pfpu_f2i_pipe.sv
// Directed bench for pfpu_f2i_pipe: default 32-bit instance plus a 64-bit instance.
module tb_pfpu_f2i_pipe;

   logic        clk = 1'b0;
   logic        rst_n, flush, adv, start, uns, start64;
   logic [1:0]  rm;
   logic [31:0] opa;
   logic [63:0] opa64;
   logic        rdy, inv, inx, rdy64, inv64, inx64;
   logic [31:0] res;
   logic [63:0] res64;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pfpu_f2i_pipe dut (
      .clk(clk), .rst(rst_n), .flush_i(flush), .adv_i(adv), .start_i(start),
      .opa_i(opa), .unsigned_i(uns), .rmode_i(rm),
      .f2i_rdy_o(rdy), .f2i_int_o(res), .f2i_inv_o(inv), .f2i_inx_o(inx)
   );

   pfpu_f2i_pipe #(.EXP_W(11), .FRAC_W(52), .INT_W(64)) dut64 (
      .clk(clk), .rst(rst_n), .flush_i(flush), .adv_i(adv), .start_i(start64),
      .opa_i(opa64), .unsigned_i(uns), .rmode_i(rm),
      .f2i_rdy_o(rdy64), .f2i_int_o(res64), .f2i_inv_o(inv64), .f2i_inx_o(inx64)
   );

   // Issue one operand and return what the pipe shows one and two edges later.
   task automatic run(input logic [31:0] a, input logic u, input logic [1:0] m,
                      output logic r_early, output logic r, output logic [31:0] v,
                      output logic iv, output logic ix);
      @(negedge clk); opa = a; uns = u; rm = m; start = 1'b1; adv = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); r_early = rdy;
      @(negedge clk); r = rdy; v = res; iv = inv; ix = inx;
   endtask

   task automatic run64(input logic [63:0] a, input logic u, input logic [1:0] m,
                        output logic r, output logic [63:0] v,
                        output logic iv, output logic ix);
      @(negedge clk); opa64 = a; uns = u; rm = m; start64 = 1'b1; adv = 1'b1;
      @(negedge clk); start64 = 1'b0;
      @(negedge clk);
      @(negedge clk); r = rdy64; v = res64; iv = inv64; ix = inx64;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; adv = 1'b1; start = 1'b0; start64 = 1'b0;
      uns = 1'b0; rm = 2'b00; opa = '0; opa64 = '0;
      repeat (2) @(negedge clk);
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", rdy); end
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL reset_int got %h exp 0", res); end
      checks++; if ({inv, inx} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {inv, inx}); end
      checks++; if ({rdy64, res64, inv64, inx64} !== 67'h0) begin errors++; $display("FAIL reset_64 got %b_%h_%b%b exp zero", rdy64, res64, inv64, inx64); end
      rst_n = 1'b1;
   endtask

   task automatic test_rounding_signed();
      logic [31:0] a  [6] = '{32'h3FC00000, 32'h3FC00000, 32'hC0200000, 32'hC0200000, 32'hC0200000, 32'h40490FDB};
      logic [1:0]  m  [6] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00};
      logic [31:0] ev [6] = '{32'd2, 32'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd3};
      logic re, r, iv, ix;
      logic [31:0] v;
      for (int i = 0; i < 6; i++) begin
         run(a[i], 1'b0, m[i], re, r, v, iv, ix);
         checks++; if ({re, r} !== 2'b01) begin errors++; $display("FAIL round[%0d] rdy early/late got %b exp 01", i, {re, r}); end
         checks++; if (v !== ev[i]) begin errors++; $display("FAIL round[%0d] int got %h exp %h", i, v, ev[i]); end
         checks++; if ({iv, ix} !== 2'b01) begin errors++; $display("FAIL round[%0d] inv/inx got %b exp 01", i, {iv, ix}); end
      end
   endtask

   task automatic test_range_edges();
      logic [31:0] a  [5] = '{32'h4F000000, 32'hCF000000, 32'h4F000000, 32'h4F7FFFFF, 32'h4F800000};
      logic        u  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] ev [5] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFF00, 32'hFFFFFFFF};
      logic [1:0]  ef [5] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
      logic re, r, iv, ix;
      logic [31:0] v;
      for (int i = 0; i < 5; i++) begin
         run(a[i], u[i], 2'b00, re, r, v, iv, ix);
         checks++; if (r !== 1'b1) begin errors++; $display("FAIL range[%0d] rdy got %b exp 1", i, r); end
         checks++; if (v !== ev[i]) begin errors++; $display("FAIL range[%0d] int got %h exp %h", i, v, ev[i]); end
         checks++; if ({iv, ix} !== ef[i]) begin errors++; $display("FAIL range[%0d] inv/inx got %b exp %b", i, {iv, ix}, ef[i]); end
      end
   endtask

   task automatic test_specials();
      logic [31:0] a  [4] = '{32'h7FC00000, 32'hFF800000, 32'h00000001, 32'h80000000};
      logic [1:0]  m  [4] = '{2'b00, 2'b00, 2'b10, 2'b00};
      logic [31:0] ev [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'h00000000};
      logic [1:0]  ef [4] = '{2'b10, 2'b10, 2'b01, 2'b00};
      logic re, r, iv, ix;
      logic [31:0] v;
      for (int i = 0; i < 4; i++) begin
         run(a[i], 1'b0, m[i], re, r, v, iv, ix);
         checks++; if (r !== 1'b1) begin errors++; $display("FAIL special[%0d] rdy got %b exp 1", i, r); end
         checks++; if (v !== ev[i]) begin errors++; $display("FAIL special[%0d] int got %h exp %h", i, v, ev[i]); end
         checks++; if ({iv, ix} !== ef[i]) begin errors++; $display("FAIL special[%0d] inv/inx got %b exp %b", i, {iv, ix}, ef[i]); end
      end
   endtask

   task automatic test_unsigned_neg();
      logic [31:0] a  [3] = '{32'hBF800000, 32'hBE800000, 32'hBF000000};
      logic [1:0]  m  [3] = '{2'b00, 2'b01, 2'b11};
      logic [1:0]  ef [3] = '{2'b10, 2'b01, 2'b10};
      logic re, r, iv, ix;
      logic [31:0] v;
      for (int i = 0; i < 3; i++) begin
         run(a[i], 1'b1, m[i], re, r, v, iv, ix);
         checks++; if (v !== 32'h0 || r !== 1'b1) begin errors++; $display("FAIL uneg[%0d] rdy/int got %b/%h exp 1/0", i, r, v); end
         checks++; if ({iv, ix} !== ef[i]) begin errors++; $display("FAIL uneg[%0d] inv/inx got %b exp %b", i, {iv, ix}, ef[i]); end
      end
   endtask

   // Five starts (1.0..5.0, RTZ); adv_i low on the third cycle stalls everything one edge.
   task automatic test_back_to_back();
      logic [31:0] ops [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
      logic        er  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int idx = 0;
      uns = 1'b0; rm = 2'b01;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k > 0) begin
            checks++; if (rdy !== er[k-1]) begin errors++; $display("FAIL b2b edge%0d rdy got %b exp %b", k-1, rdy, er[k-1]); end
            if (er[k-1]) begin
               checks++; if (res !== 32'(k-3)) begin errors++; $display("FAIL b2b edge%0d int got %h exp %h", k-1, res, 32'(k-3)); end
            end
         end
         if (k < 9) begin
            adv = (k != 2);
            if (idx < 5) begin
               start = 1'b1; opa = ops[idx];
               if (adv) idx++;
            end else begin
               start = 1'b0;
            end
         end
      end
      adv = 1'b1; start = 1'b0;
   endtask

   task automatic test_flush();
      @(negedge clk); uns = 1'b0; rm = 2'b01; adv = 1'b1; start = 1'b1; opa = 32'h3F800000;
      @(negedge clk); opa = 32'h40000000;
      @(negedge clk); opa = 32'h40400000; flush = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         start = 1'b0; flush = 1'b0;
         checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL flush[%0d] rdy got %b exp 0", j, rdy); end
      end
   endtask

   task automatic test_reset_mid();
      logic re, r, iv, ix;
      logic [31:0] v;
      @(negedge clk); uns = 1'b0; rm = 2'b01; adv = 1'b1; start = 1'b1; opa = 32'h40E00000;
      @(negedge clk); opa = 32'h41000000;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      checks++; if (rdy !== 1'b1 || res !== 32'd7) begin errors++; $display("FAIL rstmid_pre rdy/int got %b/%h exp 1/7", rdy, res); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({rdy, res, inv, inx} !== 35'h0) begin errors++; $display("FAIL rstmid_async got %b/%h/%b%b exp zero", rdy, res, inv, inx); end
      @(negedge clk); rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d] rdy got %b exp 0", j, rdy); end
      end
      run(32'h41100000, 1'b0, 2'b01, re, r, v, iv, ix);
      checks++; if (r !== 1'b1 || v !== 32'd9) begin errors++; $display("FAIL rstmid_after rdy/int got %b/%h exp 1/9", r, v); end
   endtask

   task automatic test_wide();
      logic r, iv, ix;
      logic [63:0] v;
      run64(64'h43E0000000000000, 1'b0, 2'b00, r, v, iv, ix);
      checks++; if (r !== 1'b1 || v !== 64'h7FFFFFFFFFFFFFFF) begin errors++; $display("FAIL wide_sat rdy/int got %b/%h exp 1/7fffffffffffffff", r, v); end
      checks++; if ({iv, ix} !== 2'b10) begin errors++; $display("FAIL wide_sat inv/inx got %b exp 10", {iv, ix}); end
      run64(64'h4330000000000001, 1'b0, 2'b00, r, v, iv, ix);
      checks++; if (r !== 1'b1 || v !== 64'h0010000000000001) begin errors++; $display("FAIL wide_exact rdy/int got %b/%h exp 1/0010000000000001", r, v); end
      checks++; if ({iv, ix} !== 2'b00) begin errors++; $display("FAIL wide_exact inv/inx got %b exp 00", {iv, ix}); end
   endtask

   initial begin
      test_reset();
      test_rounding_signed();
      test_range_edges();
      test_specials();
      test_unsigned_neg();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
